// File: rtl/quad_encoder.sv
// quad_encoder: turns signed motion deltas into rate-limited A/B quadrature.
// Optional build macro QENC_DOUBLE_EN: each delta unit emits two edges
// (tracked with a half-step flag), so a decoder's count[8:1] moves by delta.
module quad_encoder #(
   parameter int DW    = 8,
   parameter int ACC_W = 10,
   parameter int DIV   = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ce,
   input  logic          delta_valid,
   input  logic [DW-1:0] delta,
   input  logic          clear,
   output logic          A,
   output logic          B,
   output logic          busy,
   output logic          sat
);

   // Two guard bits so the sum of accumulator, delta and step cannot wrap.
   localparam int SW = ACC_W + 2;
   localparam logic signed [SW-1:0] PMAX = SW'((2 ** (ACC_W - 1)) - 1);
   localparam logic signed [SW-1:0] PMIN = -PMAX;
   localparam logic [7:0]           TMAX = 8'(DIV - 1);

   logic signed [ACC_W-1:0] pend_q, pend_d;
   logic [7:0]              timer_q, timer_d;
   logic                    a_q, a_d, b_q, b_d;
   logic                    busy_q, busy_d;
   logic                    sat_q, sat_d;
`ifdef QENC_DOUBLE_EN
   logic                    half_q, half_d;
`endif

   logic                    edge_c, step_c, pos_c, tog_a_c;
   logic signed [SW-1:0]    add_c, sub_c, sum_c;

   // Edge decision, phase advance, timer and saturating pending update.
   always_comb begin
      edge_c  = ce && (timer_q == TMAX) && (pend_q != '0) && !clear;
      pos_c   = !pend_q[ACC_W-1];
`ifdef QENC_DOUBLE_EN
      step_c  = edge_c && half_q;
`else
      step_c  = edge_c;
`endif
      add_c   = delta_valid ? {{(SW-DW){delta[DW-1]}}, delta} : '0;
      sub_c   = '0;
      if (step_c) sub_c = pos_c ? SW'(1) : -SW'(1);
      sum_c   = {{2{pend_q[ACC_W-1]}}, pend_q} + add_c - sub_c;

      sat_d   = 1'b0;
      pend_d  = sum_c[ACC_W-1:0];
      if (sum_c > PMAX) begin
         pend_d = PMAX[ACC_W-1:0];
         sat_d  = 1'b1;
      end else if (sum_c < PMIN) begin
         pend_d = PMIN[ACC_W-1:0];
         sat_d  = 1'b1;
      end
      if (clear) begin
         pend_d = '0;
         sat_d  = 1'b0;
      end

      // Forward: toggle A when phases match, else B; reverse swaps the roles.
      tog_a_c = ((a_q == b_q) == pos_c);
      a_d     = a_q;
      b_d     = b_q;
      if (edge_c) begin
         if (tog_a_c) a_d = !a_q;
         else         b_d = !b_q;
      end

      timer_d = timer_q;
      if (edge_c)                      timer_d = '0;
      else if (ce && timer_q != TMAX)  timer_d = timer_q + 8'd1;

`ifdef QENC_DOUBLE_EN
      half_d  = half_q;
      if (clear)       half_d = 1'b0;
      else if (edge_c) half_d = !half_q;
      busy_d  = (pend_d != '0) || half_d;
`else
      busy_d  = (pend_d != '0);
`endif
   end

   // State register with synchronous reset; timer starts ready to step.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q  <= '0;
         timer_q <= TMAX;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         sat_q   <= 1'b0;
`ifdef QENC_DOUBLE_EN
         half_q  <= 1'b0;
`endif
      end else begin
         pend_q  <= pend_d;
         timer_q <= timer_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         sat_q   <= sat_d;
`ifdef QENC_DOUBLE_EN
         half_q  <= half_d;
`endif
      end
   end

   assign A    = a_q;
   assign B    = b_q;
   assign busy = busy_q;
   assign sat  = sat_q;

endmodule

// File: tb/tb_quad_encoder.sv
// Directed bench for quad_encoder (DW=8, ACC_W=10, DIV=4) with a small
// quadrature decoder model fed from A/B for the loopback scenario.
module tb_quad_encoder;

   logic       clk = 1'b0;
   logic       reset, ce, delta_valid, clear;
   logic [7:0] delta;
   logic       A, B, busy, sat;

   int vectors = 0;
   int miscompares = 0;

   logic [1:0] prev_ab = 2'b00;
   int         dcnt = 0;
   int         nedges = 0;
   int         ndouble = 0;

   quad_encoder #(.DW(8), .ACC_W(10), .DIV(4)) dut (
      .clk(clk), .reset(reset), .ce(ce), .delta_valid(delta_valid),
      .delta(delta), .clear(clear), .A(A), .B(B), .busy(busy), .sat(sat)
   );

   always #5 clk = ~clk;

   // Advance one clock, sample after the edge, and update the decoder model.
   task automatic tick;
      @(posedge clk);
      #1;
      if ({A, B} !== prev_ab) begin
         nedges++;
         if (A ^ prev_ab[0]) dcnt++;
         else                dcnt--;
         if (A !== prev_ab[1] && B !== prev_ab[0]) ndouble++;
         prev_ab = {A, B};
      end
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      ce = 1'b1; delta_valid = 1'b0; delta = 8'd0; clear = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      prev_ab = {A, B};
      vectors++;
      if ({A, B, busy, sat} !== 4'b0000) begin
         $display("FAIL reset_state: got %b want 0000", {A, B, busy, sat});
         miscompares++;
      end
   endtask

   // delta=+3: 10 at t+2, 11 at t+6, 01 at t+10, busy falls at t+10.
   task automatic test_pos_steps;
      logic [1:0] exp_ab;
      logic       exp_busy;
      do_reset();
      delta_valid = 1'b1; delta = 8'sd3;
      tick();
      delta_valid = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) tick();
         exp_ab   = (k < 2) ? 2'b00 : (k < 6) ? 2'b10 : (k < 10) ? 2'b11 : 2'b01;
         exp_busy = (k < 10);
         vectors++;
         if ({A, B} !== exp_ab || busy !== exp_busy || sat !== 1'b0) begin
            $display("FAIL pos_steps k=%0d: AB=%b busy=%b sat=%b want AB=%b busy=%b sat=0",
                     k, {A, B}, busy, sat, exp_ab, exp_busy);
            miscompares++;
         end
      end
   endtask

   // delta=-2 from 00: 01 then 11, four clocks apart.
   task automatic test_neg_steps;
      logic [1:0] exp_ab;
      logic       exp_busy;
      do_reset();
      delta_valid = 1'b1; delta = 8'hFE;
      tick();
      delta_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) tick();
         exp_ab   = (k < 2) ? 2'b00 : (k < 6) ? 2'b01 : 2'b11;
         exp_busy = (k < 6);
         vectors++;
         if ({A, B} !== exp_ab || busy !== exp_busy) begin
            $display("FAIL neg_steps k=%0d: AB=%b busy=%b want AB=%b busy=%b",
                     k, {A, B}, busy, exp_ab, exp_busy);
            miscompares++;
         end
      end
   endtask

   // ce=0, five +127 deltas clip to 511; then drain and count 511 edges.
   task automatic test_saturate;
      int e0;
      do_reset();
      ce = 1'b0;
      delta_valid = 1'b1; delta = 8'd127;
      for (int k = 1; k <= 6; k++) begin
         if (k == 6) delta_valid = 1'b0;
         tick();
         vectors++;
         if (sat !== (k == 5) || {A, B} !== 2'b00 || busy !== 1'b1) begin
            $display("FAIL saturate k=%0d: sat=%b AB=%b busy=%b want sat=%b AB=00 busy=1",
                     k, sat, {A, B}, busy, (k == 5));
            miscompares++;
         end
      end
      e0 = nedges;
      ce = 1'b1;
      for (int k = 0; k < 3000 && busy; k++) tick();
      vectors++;
      if (busy !== 1'b0 || nedges - e0 != 511) begin
         $display("FAIL saturate_drain: edges=%0d busy=%b want edges=511 busy=0",
                  nedges - e0, busy);
         miscompares++;
      end
   endtask

   // Edge and delta in the same clock with pending=1: pending stays 1.
   task automatic test_edge_with_delta;
      do_reset();
      delta_valid = 1'b1; delta = 8'd1;
      tick();
      tick();
      delta_valid = 1'b0;
      vectors++;
      if ({A, B} !== 2'b10 || busy !== 1'b1) begin
         $display("FAIL edge_delta_first: AB=%b busy=%b want AB=10 busy=1", {A, B}, busy);
         miscompares++;
      end
      for (int k = 1; k <= 4; k++) begin
         tick();
         vectors++;
         if ({A, B} !== ((k < 4) ? 2'b10 : 2'b11) || busy !== (k < 4)) begin
            $display("FAIL edge_delta k=%0d: AB=%b busy=%b want AB=%b busy=%b",
                     k, {A, B}, busy, (k < 4) ? 2'b10 : 2'b11, (k < 4));
            miscompares++;
         end
      end
   endtask

   // clear with delta in the same clock at pending=5 wins; A/B freeze.
   task automatic test_clear;
      do_reset();
      delta_valid = 1'b1; delta = 8'd6;
      tick();
      delta_valid = 1'b0;
      tick();
      clear = 1'b1; delta_valid = 1'b1; delta = 8'd7;
      tick();
      clear = 1'b0; delta_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         vectors++;
         if ({A, B} !== 2'b10 || busy !== 1'b0) begin
            $display("FAIL clear k=%0d: AB=%b busy=%b want AB=10 busy=0", k, {A, B}, busy);
            miscompares++;
         end
         tick();
      end
   endtask

   // Reset during an active stream forces phase back to 00 and idle.
   task automatic test_reset_midstream;
      do_reset();
      delta_valid = 1'b1; delta = 8'd4;
      tick();
      delta_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if ({A, B, busy, sat} !== 4'b0000) begin
         $display("FAIL reset_midstream: got %b want 0000", {A, B, busy, sat});
         miscompares++;
      end
   endtask

   // Decoder loopback: +10 then -10, bounded wait on busy each way.
   task automatic test_loopback;
      int c0, e0, exp_n;
`ifdef QENC_DOUBLE_EN
      exp_n = 20;
`else
      exp_n = 10;
`endif
      do_reset();
      c0 = dcnt; e0 = nedges; ndouble = 0;
      delta_valid = 1'b1; delta = 8'd10;
      tick();
      delta_valid = 1'b0;
      for (int k = 0; k < 200 && busy; k++) tick();
      vectors++;
      if (busy !== 1'b0 || dcnt - c0 != exp_n || nedges - e0 != exp_n) begin
         $display("FAIL loopback_up: count=%0d edges=%0d busy=%b want count=%0d",
                  dcnt - c0, nedges - e0, busy, exp_n);
         miscompares++;
      end
      delta_valid = 1'b1; delta = 8'hF6;
      tick();
      delta_valid = 1'b0;
      for (int k = 0; k < 200 && busy; k++) tick();
      vectors++;
      if (busy !== 1'b0 || dcnt != c0) begin
         $display("FAIL loopback_down: count=%0d busy=%b want count=%0d", dcnt, busy, c0);
         miscompares++;
      end
      vectors++;
      if (ndouble != 0) begin
         $display("FAIL loopback_onehot: double toggles=%0d want 0", ndouble);
         miscompares++;
      end
   endtask

   initial begin
      test_reset();
      test_pos_steps();
      test_neg_steps();
      test_saturate();
      test_edge_with_delta();
      test_clear();
      test_reset_midstream();
      test_loopback();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
